// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DEF_WIDTH = 4;

    // Wide enough for the largest legal WIDTH; users slice the low WIDTH bits.
    localparam logic [15:0] DIV_ZERO_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {p_in[WIDTH-1:0], bit_in};
    assign trial   = shifted - {1'b0, divisor};
    // A set top bit of p_in means the true shifted value already exceeds any divisor.
    assign q_bit   = p_in[WIDTH] | (shifted >= {1'b0, divisor});
    assign p_out   = q_bit ? trial : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   step_p;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in    (p_q),
        .bit_in  (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .p_out   (step_p),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = (state_q == DONE);

        // Results publish on the edge leaving DONE, together with the done pulse.
        if (state_q == DONE) begin
            quo_d = q_q;
            rem_d = p_q[WIDTH-1:0];
            dbz_d = dz_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor != '0) begin
                        p_d     = '0;
                        q_d     = dividend;
                        dvs_d   = divisor;
                        cnt_d   = CW'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end else begin
                        p_d     = {1'b0, dividend};
                        q_d     = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        dvs_d   = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                p_d   = step_p;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's combinational Wallace multiplier.
- Produces one quotient bit per clock and reports quotient, remainder and a divide-by-zero flag.
- Used by the arithmetic test fixtures for multiply/divide round-trip checks: product / B must equal A with remainder 0.
- Start/done handshake; one divide in flight at a time.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising edge of clk
- dividend  input  WIDTH  unsigned numerator; captured when start is accepted
- divisor  input  WIDTH  unsigned denominator; captured when start is accepted
- busy  output  1  high while a division is in progress (CALC state)
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  result; held until next accepted start
- remainder  output  WIDTH  result; held until next accepted start
- div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Internal shift/count registers cleared.
- States IDLE, CALC, DONE (registered; outputs driven from registers, no combinational path from inputs to outputs).
- IDLE:
  - start=1 with divisor!=0 -> capture operands, partial remainder P=0, count=WIDTH, go CALC.
  - start=1 with divisor==0 -> go DONE directly with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- CALC, one iteration per edge:
  - Shift {P,Q} left one bit (Q = shifting dividend).
  - Trial T = P_shifted - divisor, evaluated at WIDTH+1 bits.
  - T >= 0: P=T, Q[0]=1. Otherwise P unchanged, Q[0]=0.
  - count decrements. When the iteration with count==1 completes, go DONE; quotient=Q, remainder=P, div_by_zero=0.
- DONE lasts exactly one cycle with done=1, then IDLE.
  - start in the DONE cycle is accepted exactly as from IDLE, giving back-to-back operation.
- Latency:
  - start accepted at edge k -> done high in the cycle after edge k+WIDTH+1 (WIDTH iterations plus the DONE register).
  - Divide-by-zero: done high in the cycle after edge k+1.
- busy=1 exactly during CALC, i.e. WIDTH cycles.
- start while busy is ignored: no capture, no effect on the operation in flight.
- Operand inputs may change freely after the capture edge.
- Results stay stable from done until the edge that accepts the next start, then update only at that operation's done.
- Reset mid-operation: immediately aborts to the reset values. No done pulse for the aborted divide.
- Width rules:
  - Partial remainder is WIDTH+1 bits internally; the output remainder is always < divisor, so WIDTH bits suffice.
  - quotient <= dividend; no overflow is possible for divisor != 0.

Decomposition:
- Shared package div_pkg:
  - state encoding constants IDLE/CALC/DONE.
  - DIV_ZERO_QUOTIENT constant (all ones).
  - Default WIDTH.
- One natural sub-module, div_step: combinational single iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- Basic: rst pulse, then dividend=1010 (10), divisor=0011 (3), start 1 cycle -> busy for 4 cycles; done pulse 5 cycles after the start edge; quotient=0011 (3), remainder=0001 (1), div_by_zero=0.
- Round trip: multiplier A=1010, B=0011 gives product 30. Using WIDTH=8 with dividend=30, divisor=3 -> quotient=10, remainder=0.
- Edge values: 15/1 -> q=15, r=0. 3/5 -> q=0, r=3. 15/15 -> q=1, r=0. 0/7 -> q=0, r=0.
- Divide by zero: 7/0 -> done one cycle later; div_by_zero=1, quotient=1111, remainder=0111, busy never asserted.
- Protocol:
  - start pulsed again mid-CALC with other operands -> ignored; original result delivered.
  - start held high through the DONE cycle -> second divide accepted back-to-back; results correct for both.
- Reset mid-op: rst asserted asynchronously (between edges) 2 cycles into CALC -> outputs at reset values immediately; no done pulse. The next divide 9/2 gives q=4, r=1.
